// File: rtl/block_tile_feeder_pkg.sv
// Shared defaults, output-FSM encoding and the tile packing helper for the
// block tile feeder and its fill buffer.
package block_tile_feeder_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_DIM     = 4;
  localparam int DEF_K_TILES = 4;

  typedef logic [1:0] fsm_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  // Element 0 lands in the MSBs of a packed tile.
  function automatic int elem_msb(input int tile_w, input int data_w, input int n);
    return tile_w - 1 - data_w * n;
  endfunction

endpackage

// File: rtl/block_tile_feeder_if.sv
// Bundle of the upstream element stream and the systolic-stage tile handshake.
interface block_tile_feeder_if
  import block_tile_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM    = DEF_DIM
);

  localparam int TILE_W = DIM * DIM * DATA_W;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [TILE_W-1:0] tile_a;
  logic [TILE_W-1:0] tile_b;
  logic              tile_start;
  logic              accum_clear;
  logic              tile_done;
  logic              block_done;

  modport master (
    output in_valid, in_data, tile_done,
    input  in_ready, tile_a, tile_b, tile_start, accum_clear, block_done
  );

  modport slave (
    input  in_valid, in_data, tile_done,
    output in_ready, tile_a, tile_b, tile_start, accum_clear, block_done
  );

endinterface

// File: rtl/block_tile_feeder_tile_fill_buffer.sv
// Fill side of the feeder: collects one A tile then one B tile from the
// element stream and holds them until the output side takes the pair.
module tile_fill_buffer
  import block_tile_feeder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIM    = DEF_DIM,
  localparam int TILE_W = DIM * DIM * DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              fill_clear,
  output logic              in_ready,
  output logic [TILE_W-1:0] fill_a,
  output logic [TILE_W-1:0] fill_b,
  output logic              fill_full
);

  localparam int ELEMS = DIM * DIM;
  localparam int WORDS = 2 * ELEMS;
  localparam int CNT_W = $clog2(WORDS);

  logic [CNT_W-1:0] word_cnt;
  logic             accept;
  int               word_idx;

  assign in_ready = !fill_full;
  assign accept   = in_valid && !fill_full;
  assign word_idx = int'(word_cnt);

  // A full pair blocks further input until the output side copies it out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_cnt  <= '0;
      fill_full <= 1'b0;
      fill_a    <= '0;
      fill_b    <= '0;
    end else begin
      if (fill_clear)
        fill_full <= 1'b0;
      if (accept) begin
        if (word_idx < ELEMS)
          fill_a[elem_msb(TILE_W, DATA_W, word_idx) -: DATA_W] <= in_data;
        else
          fill_b[elem_msb(TILE_W, DATA_W, word_idx - ELEMS) -: DATA_W] <= in_data;
        if (word_idx == WORDS - 1) begin
          word_cnt  <= '0;
          fill_full <= 1'b1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/block_tile_feeder.sv
// Double-buffered tile feeder: hands completed A/B tile pairs to the systolic
// stage and tracks accumulation progress across K_TILES pairs per block.
module block_tile_feeder
  import block_tile_feeder_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DIM     = DEF_DIM,
  parameter int K_TILES = DEF_K_TILES
) (
  input  logic               clock,
  input  logic               reset,
  block_tile_feeder_if.slave bus
);

  localparam int TILE_W = DIM * DIM * DATA_W;
  localparam int TC_W   = (K_TILES > 1) ? $clog2(K_TILES) : 1;

  fsm_state_t        state;
  logic [TC_W-1:0]   tile_cnt;
  logic              fill_full;
  logic              fill_clear;
  logic [TILE_W-1:0] fill_a;
  logic [TILE_W-1:0] fill_b;
  logic [TILE_W-1:0] tile_a_q;
  logic [TILE_W-1:0] tile_b_q;
  logic              tile_start_q;
  logic              accum_clear_q;
  logic              block_done_q;
  logic              last_tile;

  assign fill_clear = (state == ST_LOAD);
  assign last_tile  = (int'(tile_cnt) == K_TILES - 1);

  tile_fill_buffer #(
    .DATA_W (DATA_W),
    .DIM    (DIM)
  ) u_fill (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (bus.in_valid),
    .in_data    (bus.in_data),
    .fill_clear (fill_clear),
    .in_ready   (bus.in_ready),
    .fill_a     (fill_a),
    .fill_b     (fill_b),
    .fill_full  (fill_full)
  );

  // The pair is copied on the edge entering LOAD so the tiles are already
  // stable while tile_start is high; the fill buffer is released on LOAD exit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      tile_cnt      <= '0;
      tile_a_q      <= '0;
      tile_b_q      <= '0;
      tile_start_q  <= 1'b0;
      accum_clear_q <= 1'b0;
      block_done_q  <= 1'b0;
    end else begin
      tile_start_q  <= 1'b0;
      accum_clear_q <= 1'b0;
      block_done_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fill_full) begin
            state         <= ST_LOAD;
            tile_a_q      <= fill_a;
            tile_b_q      <= fill_b;
            tile_start_q  <= 1'b1;
            accum_clear_q <= (tile_cnt == '0);
          end
        end
        ST_LOAD: begin
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          if (bus.tile_done) begin
            state        <= ST_IDLE;
            block_done_q <= last_tile;
            tile_cnt     <= last_tile ? '0 : tile_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tile_a      = tile_a_q;
  assign bus.tile_b      = tile_b_q;
  assign bus.tile_start  = tile_start_q;
  assign bus.accum_clear = accum_clear_q;
  assign bus.block_done  = block_done_q;

endmodule

// File: tb/tb_block_tile_feeder.sv
// Self-checking bench for block_tile_feeder: scoreboarded tile pairs, a
// table of block-progress vectors and hand sequences for stall/reset cases.
module tb_block_tile_feeder;

  localparam int DATA_W  = 16;
  localparam int DIM     = 4;
  localparam int K_TILES = 4;
  localparam int ELEMS   = DIM * DIM;
  localparam int TILE_W  = DIM * DIM * DATA_W;

  typedef struct {
    logic [TILE_W-1:0] a;
    logic [TILE_W-1:0] b;
    logic              clr;
  } pair_t;

  typedef struct {
    logic [DATA_W-1:0] base;
    logic              exp_clr;
    int                exp_bd;
  } vec_t;

  logic clock;
  logic reset;

  block_tile_feeder_if #(.DATA_W(DATA_W), .DIM(DIM)) bus ();

  block_tile_feeder #(
    .DATA_W  (DATA_W),
    .DIM     (DIM),
    .K_TILES (K_TILES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  pair_t exp_q[$];
  pair_t obs_q[$];
  int    bd_count = 0;
  int    total = 0;
  int    bad = 0;

  // Record every tile handoff and block completion seen on the bus.
  always @(negedge clock) begin
    if (bus.tile_start)
      obs_q.push_back('{a: bus.tile_a, b: bus.tile_b, clr: bus.accum_clear});
    if (bus.block_done)
      bd_count++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [TILE_W-1:0] pack_tile(input int first);
    logic [TILE_W-1:0] t;
    t = '0;
    for (int n = 0; n < ELEMS; n++)
      t[TILE_W-1-DATA_W*n -: DATA_W] = DATA_W'(first + n);
    return t;
  endfunction

  task automatic check_output(input string name, input logic [TILE_W-1:0] act,
                              input logic [TILE_W-1:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] v);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.in_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL send_timeout: actual=stalled required=accepted word=%0h", v);
    end
  endtask

  task automatic apply_stimulus(input logic [DATA_W-1:0] base, input logic clr);
    exp_q.push_back('{a: pack_tile(int'(base)), b: pack_tile(int'(base) + ELEMS), clr: clr});
    for (int i = 0; i < 2 * ELEMS; i++)
      send_word(base + DATA_W'(i));
    bus.in_valid = 1'b0;
    bus.in_data  = DATA_W'($urandom);
  endtask

  task automatic wait_obs();
    for (int i = 0; i < 40 && obs_q.size() == 0; i++)
      tick(1);
  endtask

  task automatic check_pair(input string name);
    pair_t e;
    pair_t o;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: actual=obs%0d/exp%0d required=pair available", name,
               obs_q.size(), exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    check_output({name, "_tile_a"}, o.a, e.a);
    check_output({name, "_tile_b"}, o.b, e.b);
    check_output({name, "_accum_clear"}, TILE_W'(o.clr), TILE_W'(e.clr));
  endtask

  task automatic pulse_done();
    bus.tile_done = 1'b1;
    tick(1);
    bus.tile_done = 1'b0;
    tick(3);
  endtask

  vec_t vecs[4];
  int   bd0;

  initial begin
    vecs[0] = '{base: 16'h0100, exp_clr: 1'b0, exp_bd: 0};
    vecs[1] = '{base: 16'h0200, exp_clr: 1'b0, exp_bd: 0};
    vecs[2] = '{base: 16'h0300, exp_clr: 1'b0, exp_bd: 1};
    vecs[3] = '{base: 16'h0400, exp_clr: 1'b1, exp_bd: 0};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.tile_done = 1'b0;
    tick(3);
    check_output("rst_in_ready", TILE_W'(bus.in_ready), TILE_W'(1));
    check_output("rst_tile_start", TILE_W'(bus.tile_start), '0);
    check_output("rst_accum_clear", TILE_W'(bus.accum_clear), '0);
    check_output("rst_block_done", TILE_W'(bus.block_done), '0);
    check_output("rst_tile_a", bus.tile_a, '0);
    check_output("rst_tile_b", bus.tile_b, '0);
    reset = 1'b1;
    tick(1);

    // First pair: tile_start must appear exactly two cycles after the last accept.
    apply_stimulus(16'd1, 1'b1);
    check_output("lat_start_early", TILE_W'(bus.tile_start), '0);
    tick(1);
    check_output("lat_start", TILE_W'(bus.tile_start), TILE_W'(1));
    check_output("lat_clear", TILE_W'(bus.accum_clear), TILE_W'(1));
    check_output("a_first_elem", TILE_W'(bus.tile_a[255:240]), TILE_W'(1));
    check_output("a_last_elem", TILE_W'(bus.tile_a[15:0]), TILE_W'(16));
    check_output("b_first_elem", TILE_W'(bus.tile_b[255:240]), TILE_W'(17));
    check_output("b_last_elem", TILE_W'(bus.tile_b[15:0]), TILE_W'(32));
    wait_obs();
    check_pair("pair1");
    bd0 = bd_count;
    pulse_done();
    check_output("pair1_block_done", TILE_W'(bd_count - bd0), '0);

    for (int v = 0; v < 4; v++) begin
      apply_stimulus(vecs[v].base, vecs[v].exp_clr);
      wait_obs();
      check_pair($sformatf("vec%0d", v));
      bd0 = bd_count;
      pulse_done();
      check_output($sformatf("vec%0d_block_done", v), TILE_W'(bd_count - bd0),
                   TILE_W'(vecs[v].exp_bd));
    end

    // tile_done while IDLE must not advance the block.
    bd0 = bd_count;
    pulse_done();
    check_output("idle_done_block_done", TILE_W'(bd_count - bd0), '0);
    check_output("idle_done_no_start", TILE_W'(obs_q.size()), '0);

    // Two pairs back to back with the stage busy: the second must stall.
    apply_stimulus(16'h0500, 1'b0);
    apply_stimulus(16'h0600, 1'b0);
    tick(2);
    check_output("stall_in_ready", TILE_W'(bus.in_ready), '0);
    check_output("stall_one_loaded", TILE_W'(obs_q.size()), TILE_W'(1));
    check_pair("stall_pair1");
    tick(5);
    check_output("stall_second_held", TILE_W'(obs_q.size()), '0);
    bd0 = bd_count;
    pulse_done();
    check_pair("stall_pair2");
    check_output("stall_in_ready_back", TILE_W'(bus.in_ready), TILE_W'(1));
    pulse_done();
    apply_stimulus(16'h0700, 1'b0);
    wait_obs();
    check_pair("blk2_last");
    pulse_done();
    check_output("blk2_block_done", TILE_W'(bd_count - bd0), TILE_W'(1));

    // Reset in the middle of a fill discards the partial pair.
    for (int i = 0; i < 20; i++)
      send_word(16'h0800 + 16'(i));
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #2;
    check_output("mid_rst_in_ready", TILE_W'(bus.in_ready), TILE_W'(1));
    check_output("mid_rst_tile_a", bus.tile_a, '0);
    check_output("mid_rst_tile_b", bus.tile_b, '0);
    check_output("mid_rst_tile_start", TILE_W'(bus.tile_start), '0);
    tick(2);
    reset = 1'b1;
    tick(1);
    exp_q.delete();
    obs_q.delete();
    apply_stimulus(16'h0900, 1'b1);
    wait_obs();
    check_output("post_rst_first_elem", TILE_W'(bus.tile_a[255:240]), TILE_W'(16'h0900));
    check_pair("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_tile_feeder.md
BLOCK_TILE_FEEDER -- requirements
Module: block_tile_feeder

Interface
REQ-001 Parameter: DATA_W, default 16, element width in bits.
REQ-002 Parameter: DIM, default 4, tile edge; a tile holds DIM*DIM elements.
REQ-003 Parameter: K_TILES, default 4, number of A/B tile pairs accumulated into one output block.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream element valid.
REQ-007 in_data  input  DATA_W  upstream element, row-major; A tile first, then B tile.
REQ-008 in_ready  output  1  element accepted on a clock edge where in_valid and in_ready are both high.
REQ-009 tile_a  output  DIM*DIM*DATA_W  packed A tile sent to the systolic stage (input_1).
REQ-010 tile_b  output  DIM*DIM*DATA_W  packed B tile sent to the systolic stage (input_2).
REQ-011 tile_start  output  1  one-cycle pulse; tile_a and tile_b are valid from this cycle on.
REQ-012 accum_clear  output  1  one-cycle pulse, coincident with tile_start for the first tile pair of a block.
REQ-013 tile_done  input  1  done_systolic from the systolic stage.
REQ-014 block_done  output  1  one-cycle pulse after the last tile pair of a block completes.

Function
REQ-015 Fill side: a word counter runs 0..2*DIM*DIM-1 (0..31 by default).
- Words 0..15 are written to the A fill buffer.
- Words 16..31 are written to the B fill buffer.
- Element n is placed at bits [W-1-DATA_W*n -: DATA_W], with W = DIM*DIM*DATA_W, so element 0 occupies the MSBs.
REQ-016 Acceptance of word 31 sets fill_full and wraps the word counter to 0.
REQ-017 in_ready = !fill_full.
- in_ready is low for exactly the cycles in which fill_full is set.
- No element is accepted in the cycle in which the transfer clears fill_full.
REQ-018 The output FSM has three states: IDLE, LOAD, BUSY.
- IDLE -> LOAD when fill_full = 1.
- LOAD -> BUSY unconditionally.
- BUSY -> IDLE when tile_done = 1.
REQ-019 In LOAD:
- the fill buffers are copied into the tile_a/tile_b registers;
- fill_full is cleared;
- tile_start is pulsed.
Latency: the last word is accepted at edge E; tile_start is high during the cycle after edge E+1, provided the FSM was in IDLE at edge E.
REQ-020 tile_a and tile_b hold their values from LOAD until the next LOAD. This gives double buffering: the next pair fills while the current pair is BUSY.
REQ-021 A tile counter runs 0..K_TILES-1.
- accum_clear = tile_start && (tile_cnt == 0).
- tile_cnt increments on tile_done in BUSY and wraps to 0 after K_TILES-1.
REQ-022 block_done is high for one cycle, registered, on the edge after tile_done is accepted in BUSY while tile_cnt == K_TILES-1.
REQ-023 tile_done is ignored in IDLE and LOAD.
REQ-024 in_valid is ignored while in_ready = 0. in_data is a don't-care when in_valid = 0.
REQ-025 If fill_full is set while the FSM is BUSY, the transfer waits for IDLE. Upstream stalls until then, and no data is lost or overwritten.

Reset
REQ-026 reset low clears, asynchronously and in any state:
- word counter, tile_cnt and fill_full to 0;
- FSM to IDLE;
- tile_a and tile_b to 0;
- tile_start, accum_clear and block_done to 0;
- in_ready to 1 (its reset value).
REQ-027 Reset asserted mid-fill or mid-BUSY discards the partial tile and the block progress. After release, the first accepted word is element 0 of A, and tile_cnt is 0.

Structure
REQ-028 The shared package holds DATA_W, DIM, K_TILES defaults, the FSM state encoding (2 bits: IDLE=0, LOAD=1, BUSY=2) and the packing-offset helper.
REQ-029 There is one sub-module, tile_fill_buffer, instantiated once. It holds the word counter, the A/B fill registers and fill_full. The FSM and tile counter live in the top module.

Verification
REQ-030 After reset, stream 32 words with values 1..32 and hold tile_done low:
- tile_a[255:240] = 1 and tile_a[15:0] = 16;
- tile_b[255:240] = 17 and tile_b[15:0] = 32;
- one tile_start with accum_clear = 1, two cycles after the last accept.
REQ-031 Stream 64 words back-to-back with tile_done held low:
- in_ready drops after word 64;
- the second pair is not loaded;
- tile_done pulses -> second tile_start with accum_clear = 0 and new tile_a contents, and in_ready returns to 1.
REQ-032 K_TILES=4, four pairs, each completed by a tile_done pulse -> accum_clear only on pair 1, block_done exactly once after the 4th tile_done, tile_cnt back to 0.
REQ-033 Pulse tile_done while IDLE -> no block_done and no counter change.
REQ-034 Assert reset after word 20 -> all outputs 0, in_ready = 1. Then stream 32 words -> tile_a[255:240] equals the first post-reset word.
